// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one outstanding data-memory access, stalling the
// front of the pipe until the ack, then formatting load data into the WB registers.
module mem_stage_lsu (
  input  logic               clk,
  input  logic               rst,
  input  logic               regwriteM,
  input  logic               memwriteM,
  input  logic signed [2:0]  resultsrcM,
  input  logic signed [2:0]  loadsrcM,
  input  logic        [4:0]  rdM,
  input  logic        [31:0] aluresultM,
  input  logic        [31:0] writeDataM,
  input  logic        [31:0] auipcM,
  input  logic        [31:0] immextM,
  input  logic        [31:0] pcplus4M,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic        [31:0] dmem_addr,
  output logic        [31:0] dmem_wdata,
  output logic        [3:0]  dmem_be,
  input  logic               dmem_ack,
  input  logic        [31:0] dmem_rdata,
  output logic               stallM,
  output logic               regwriteW,
  output logic        [4:0]  rdW,
  output logic        [31:0] resultW,
  output logic               misalignW
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic        is_load, is_store, access, is_half, is_byte, misaligned;
  logic [31:0] st_wdata, alu_mux, idle_result, lane, ld_data;
  logic [3:0]  st_be;

  logic        is_load_q, regwrite_q;
  logic [4:0]  rd_q;
  logic [2:0]  loadsrc_q;
  logic [1:0]  off_q;

  always_comb begin
    is_load  = (resultsrcM == 3'd1) && !memwriteM;
    is_store = memwriteM;
    access   = is_load || is_store;
    is_half  = 1'b0;
    is_byte  = 1'b0;
    if (is_store) begin
      is_half = (loadsrcM == 3'd1);
      is_byte = (loadsrcM == 3'd2);
    end else begin
      is_half = (loadsrcM == 3'd1) || (loadsrcM == 3'd3);
      is_byte = (loadsrcM == 3'd2) || (loadsrcM == 3'd4);
    end
    misaligned = 1'b0;
    if (access) begin
      if (is_byte)      misaligned = 1'b0;
      else if (is_half) misaligned = aluresultM[0];
      else              misaligned = (aluresultM[1:0] != 2'b00);
    end
  end

  // Store lanes: replicate narrow data across the word, enable only the addressed bytes.
  always_comb begin
    st_wdata = writeDataM;
    st_be    = 4'b1111;
    if (is_byte) begin
      st_wdata = {4{writeDataM[7:0]}};
      st_be    = 4'b0001 << aluresultM[1:0];
    end else if (is_half) begin
      st_wdata = {2{writeDataM[15:0]}};
      st_be    = aluresultM[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    case (resultsrcM)
      3'd2:    alu_mux = pcplus4M;
      3'd3:    alu_mux = immextM;
      3'd4:    alu_mux = auipcM;
      default: alu_mux = aluresultM;
    endcase
    // A misaligned load never reaches memory, so there is no data to return.
    idle_result = is_load ? 32'h0 : alu_mux;
  end

  always_comb begin
    lane = dmem_rdata >> {off_q, 3'b000};
    case (loadsrc_q)
      3'd1:    ld_data = {{16{lane[15]}}, lane[15:0]};
      3'd2:    ld_data = {{24{lane[7]}}, lane[7:0]};
      3'd3:    ld_data = {16'h0, lane[15:0]};
      3'd4:    ld_data = {24'h0, lane[7:0]};
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    if (rst)               stallM = 1'b0;
    else if (state == IDLE) stallM = access && !misaligned;
    else                   stallM = !dmem_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'h0;
      regwriteW  <= 1'b0;
      rdW        <= 5'd0;
      resultW    <= 32'h0;
      misalignW  <= 1'b0;
      is_load_q  <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      loadsrc_q  <= 3'd0;
      off_q      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !misaligned) begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {aluresultM[31:2], 2'b00};
            dmem_wdata <= is_store ? st_wdata : 32'h0;
            dmem_be    <= is_store ? st_be : 4'b1111;
            is_load_q  <= is_load;
            regwrite_q <= regwriteM && is_load;
            rd_q       <= rdM;
            loadsrc_q  <= loadsrcM;
            off_q      <= aluresultM[1:0];
            regwriteW  <= 1'b0;
            rdW        <= 5'd0;
            resultW    <= 32'h0;
            misalignW  <= 1'b0;
          end else begin
            regwriteW  <= regwriteM && !misaligned && !is_store;
            rdW        <= rdM;
            resultW    <= idle_result;
            misalignW  <= misaligned;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            regwriteW <= regwrite_q;
            rdW       <= rd_q;
            resultW   <= is_load_q ? ld_data : alu_mux;
            misalignW <= 1'b0;
          end else begin
            regwriteW <= 1'b0;
            rdW       <= 5'd0;
            resultW   <= 32'h0;
            misalignW <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected WB results and memory requests are queued
// at issue time and checked by independent monitors.
module tb_mem_stage_lsu;

  logic               clk = 1'b0;
  logic               rst;
  logic               regwriteM, memwriteM;
  logic signed [2:0]  resultsrcM, loadsrcM;
  logic        [4:0]  rdM;
  logic        [31:0] aluresultM, writeDataM, auipcM, immextM, pcplus4M;
  logic               dmem_req, dmem_we, dmem_ack;
  logic        [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        [3:0]  dmem_be;
  logic               stallM, regwriteW, misalignW;
  logic        [4:0]  rdW;
  logic        [31:0] resultW;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .memwriteM(memwriteM), .resultsrcM(resultsrcM), .loadsrcM(loadsrcM),
    .rdM(rdM), .aluresultM(aluresultM), .writeDataM(writeDataM), .auipcM(auipcM),
    .immextM(immextM), .pcplus4M(pcplus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stallM(stallM), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] res; logic rw; logic mis; logic chk_res; } wb_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; } dm_t;

  wb_t wb_q[$];
  dm_t dm_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // WB monitor: any visible writeback or misalign flag is a completed instruction.
  always @(negedge clk) begin
    if (!rst && (regwriteW || misalignW)) begin
      if (wb_q.size() == 0) begin
        check("unexpected_wb_event", {26'h0, regwriteW, rdW}, 32'h0);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_rd", {27'h0, rdW}, {27'h0, e.rd});
        check("wb_regwrite", {31'h0, regwriteW}, {31'h0, e.rw});
        check("wb_misalign", {31'h0, misalignW}, {31'h0, e.mis});
        if (e.chk_res) check("wb_result", resultW, e.res);
      end
    end
  end

  // Memory-request monitor: new request pops an expectation; held every cycle until ack.
  logic req_q = 1'b0;
  dm_t  cur;
  always @(negedge clk) begin
    if (!rst && dmem_req) begin
      if (!req_q) begin
        if (dm_q.size() == 0) begin
          check("unexpected_dmem_req", {31'h0, dmem_req}, 32'h0);
          cur = '{addr: dmem_addr, wdata: dmem_wdata, be: dmem_be, we: dmem_we};
        end else begin
          cur = dm_q.pop_front();
        end
      end
      check("dmem_addr", dmem_addr, cur.addr);
      check("dmem_be", {28'h0, dmem_be}, {28'h0, cur.be});
      check("dmem_we", {31'h0, dmem_we}, {31'h0, cur.we});
      if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
    end
    req_q = dmem_req && !rst;
  end

  task automatic set_op(input logic rw, input logic mw, input logic [2:0] rs, input logic [2:0] ls,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    regwriteM = rw; memwriteM = mw; resultsrcM = rs; loadsrcM = ls;
    rdM = rd; aluresultM = alu; writeDataM = wd;
  endtask

  // Runs the currently driven op to completion; ack comes after ack_delay non-ack BUSY cycles.
  task automatic do_op(input int ack_delay, output int stalls);
    int  busy;
    bit  done;
    busy = 0; stalls = 0; done = 0;
    dmem_ack = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (dmem_req) begin
        if (busy == ack_delay) dmem_ack = 1'b1;
        busy++;
      end
      #1;
      if (stallM) stalls++;
      done = !stallM;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    if (!done) check("op_timeout", 32'h1, 32'h0);
  endtask

  task automatic nop();
    set_op(1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 32'h0, 32'h0);
  endtask

  int stalls;
  logic [2:0]  mux_rs  [5] = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic [31:0] mux_exp [5] = '{32'h0000_1004, 32'hABCD_E000, 32'h2000_1000, 32'h0000_0077, 32'h0000_0077};
  logic [4:0]  mux_rd  [5] = '{5'd11, 5'd12, 5'd13, 5'd0, 5'd15};

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    auipcM = 32'h2000_1000; immextM = 32'hABCD_E000; pcplus4M = 32'h0000_1004;
    nop();
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("rst_stallM", {31'h0, stallM}, 32'h0);
    check("rst_regwriteW", {31'h0, regwriteW}, 32'h0);
    check("rst_resultW", resultW, 32'h0);
    check("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU op
    set_op(1'b1, 1'b0, 3'd0, 3'd0, 5'd5, 32'h0000_1234, 32'h0);
    wb_q.push_back('{rd: 5'd5, res: 32'h1234, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    check("alu_stalls", stalls, 0);
    nop(); @(posedge clk); #1;

    // Result mux for the non-memory sources, including out-of-range selectors and rd=0
    for (int i = 0; i < 5; i++) begin
      set_op(1'b1, 1'b0, mux_rs[i], 3'd0, mux_rd[i], 32'h77, 32'h0);
      wb_q.push_back('{rd: mux_rd[i], res: mux_exp[i], rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
      do_op(0, stalls);
    end
    nop(); @(posedge clk); #1;

    // sb with regwriteM set: must not write back
    set_op(1'b1, 1'b1, 3'd0, 3'd2, 5'd7, 32'h0000_0103, 32'h0000_00AB);
    dm_q.push_back('{addr: 32'h100, wdata: 32'hABAB_ABAB, be: 4'b1000, we: 1'b1});
    do_op(3, stalls);
    check("sb_stalls", stalls, 4);
    check("sb_regwriteW", {31'h0, regwriteW}, 32'h0);
    nop(); @(posedge clk); #1;

    // sh and sw lane placement
    set_op(1'b0, 1'b1, 3'd0, 3'd1, 5'd0, 32'h0000_0102, 32'h1234_CDEF);
    dm_q.push_back('{addr: 32'h100, wdata: 32'hCDEF_CDEF, be: 4'b1100, we: 1'b1});
    do_op(1, stalls);
    check("sh_stalls", stalls, 2);
    set_op(1'b0, 1'b1, 3'd0, 3'd0, 5'd0, 32'h0000_0104, 32'hDEAD_BEEF);
    dm_q.push_back('{addr: 32'h104, wdata: 32'hDEAD_BEEF, be: 4'b1111, we: 1'b1});
    do_op(0, stalls);
    nop(); @(posedge clk); #1;

    // Loads from 0x202 / 0x200 / 0x203, zero-wait
    dmem_rdata = 32'h0080_FF00;
    set_op(1'b1, 1'b0, 3'd1, 3'd2, 5'd10, 32'h0000_0202, 32'h0);
    dm_q.push_back('{addr: 32'h200, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    wb_q.push_back('{rd: 5'd10, res: 32'hFFFF_FF80, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    check("lb_stalls", stalls, 1);
    set_op(1'b1, 1'b0, 3'd1, 3'd4, 5'd10, 32'h0000_0202, 32'h0);
    dm_q.push_back('{addr: 32'h200, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    wb_q.push_back('{rd: 5'd10, res: 32'h0000_0080, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    set_op(1'b1, 1'b0, 3'd1, 3'd1, 5'd10, 32'h0000_0202, 32'h0);
    dm_q.push_back('{addr: 32'h200, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    wb_q.push_back('{rd: 5'd10, res: 32'h0000_0080, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    set_op(1'b1, 1'b0, 3'd1, 3'd1, 5'd8, 32'h0000_0200, 32'h0);
    dm_q.push_back('{addr: 32'h200, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    wb_q.push_back('{rd: 5'd8, res: 32'hFFFF_FF00, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(2, stalls);
    check("lh_wait_stalls", stalls, 3);
    set_op(1'b1, 1'b0, 3'd1, 3'd3, 5'd8, 32'h0000_0200, 32'h0);
    dm_q.push_back('{addr: 32'h200, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    wb_q.push_back('{rd: 5'd8, res: 32'h0000_FF00, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    dmem_rdata = 32'h7F00_FF00;
    set_op(1'b1, 1'b0, 3'd1, 3'd2, 5'd9, 32'h0000_0203, 32'h0);
    dm_q.push_back('{addr: 32'h200, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    wb_q.push_back('{rd: 5'd9, res: 32'h0000_007F, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    nop(); @(posedge clk); #1;

    // Misaligned accesses complete in one cycle, no memory request
    set_op(1'b1, 1'b0, 3'd1, 3'd0, 5'd3, 32'h0000_0206, 32'h0);
    wb_q.push_back('{rd: 5'd3, res: 32'h0, rw: 1'b0, mis: 1'b1, chk_res: 1'b0});
    do_op(0, stalls);
    check("lw_mis_stalls", stalls, 0);
    set_op(1'b1, 1'b0, 3'd1, 3'd1, 5'd4, 32'h0000_0201, 32'h0);
    wb_q.push_back('{rd: 5'd4, res: 32'h0, rw: 1'b0, mis: 1'b1, chk_res: 1'b0});
    do_op(0, stalls);
    set_op(1'b0, 1'b1, 3'd0, 3'd1, 5'd0, 32'h0000_0101, 32'h55);
    wb_q.push_back('{rd: 5'd0, res: 32'h0, rw: 1'b0, mis: 1'b1, chk_res: 1'b0});
    do_op(0, stalls);
    nop(); @(posedge clk); #1;

    // Reset in the second BUSY cycle of a load
    dmem_rdata = 32'hCAFE_F00D;
    set_op(1'b1, 1'b0, 3'd1, 3'd0, 5'd9, 32'h0000_0300, 32'h0);
    dm_q.push_back('{addr: 32'h300, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    check("midrst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("midrst_stallM", {31'h0, stallM}, 32'h0);
    check("midrst_dmem_addr", dmem_addr, 32'h0);
    nop();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; dmem_ack = 1'b1;
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk);
    check("post_rst_ack_regwriteW", {31'h0, regwriteW}, 32'h0);
    check("post_rst_ack_resultW", resultW, 32'h0);
    check("post_rst_ack_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;

    // Back-to-back: zero-wait lw then ALU op
    dmem_rdata = 32'h1122_3344;
    set_op(1'b1, 1'b0, 3'd1, 3'd0, 5'd4, 32'h0000_0400, 32'h0);
    dm_q.push_back('{addr: 32'h400, wdata: 32'h0, be: 4'b1111, we: 1'b0});
    wb_q.push_back('{rd: 5'd4, res: 32'h1122_3344, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    check("b2b_lw_stalls", stalls, 1);
    set_op(1'b1, 1'b0, 3'd0, 3'd0, 5'd6, 32'h0000_0055, 32'h0);
    wb_q.push_back('{rd: 5'd6, res: 32'h55, rw: 1'b1, mis: 1'b0, chk_res: 1'b1});
    do_op(0, stalls);
    check("b2b_alu_stalls", stalls, 0);
    nop();
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("wb_queue_drained", wb_q.size(), 0);
    check("dm_queue_drained", dm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have ports `clk` (in, 1, the single clock) and `rst` (in, 1); reset is asynchronous and active-high.
REQ-002 It SHALL take these M-stage inputs: `regwriteM` (1), `memwriteM` (1), `resultsrcM` (3, signed), `loadsrcM` (3, signed), `rdM` (5), and `aluresultM`, `writeDataM`, `auipcM`, `immextM`, `pcplus4M` (32 each).
REQ-003 `aluresultM` SHALL be the effective address; `writeDataM` SHALL be the raw store data.
REQ-004 It SHALL drive these data-memory outputs: `dmem_req` (1), `dmem_we` (1), `dmem_addr` (32), `dmem_wdata` (32), `dmem_be` (4).
REQ-005 It SHALL take these data-memory inputs: `dmem_ack` (1) and `dmem_rdata` (32).
REQ-006 `stallM` (out, 1) SHALL be high when the IF/ID/EX stages and the EX/MM register must hold.
REQ-007 It SHALL drive these WB outputs: `regwriteW` (1), `rdW` (5), `resultW` (32), `misalignW` (1).

Function
REQ-008 resultsrcM encoding SHALL be: 0 ALU, 1 load data, 2 pcplus4, 3 immext (lui), 4 auipc; values 5-7 SHALL select ALU.
REQ-009 loadsrcM encoding SHALL be:
- loads: 0 lw, 1 lh, 2 lb, 3 lhu, 4 lbu;
- stores: 0 sw, 1 sh, 2 sb;
- any other value SHALL be treated as word.
REQ-010 Load SHALL mean resultsrcM==1 and memwriteM==0; store SHALL mean memwriteM==1; access SHALL mean load or store.
REQ-011 Misalignment rules SHALL be:
- word access misaligned when addr[1:0]!=0;
- half access misaligned when addr[0]!=0;
- byte access never misaligned.
REQ-012 The FSM SHALL have two states, IDLE and BUSY.
REQ-013 In IDLE with an aligned access, the block SHALL assert stallM combinationally and go to BUSY at the next edge.
REQ-014 On entry to BUSY, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL be registered, and SHALL be held stable until the cycle in which dmem_ack is sampled high.
REQ-015 In BUSY, stallM SHALL be the inverse of dmem_ack; the cycle with ack SHALL be the completion cycle.
REQ-016 At the completion edge the block SHALL return to IDLE, deassert dmem_req, and load the WB registers.
REQ-017 Zero-wait memory (ack in the first BUSY cycle) SHALL give a 2-cycle memory-op occupancy.
REQ-018 A non-access op, or a misaligned access, SHALL complete in IDLE in 1 cycle with stallM=0 and no dmem_req.
REQ-019 dmem_ack while in IDLE SHALL be ignored.
REQ-020 During every stalled cycle the WB registers SHALL load a bubble: regwriteW=0, misalignW=0, rdW=0, resultW=0.
REQ-021 dmem_addr SHALL be {aluresultM[31:2],2'b00}.
REQ-022 For stores, dmem_wdata and dmem_be SHALL be:
- sw: data unchanged, be 4'b1111;
- sh: low half replicated to both halves, be 4'b0011 if addr[1]==0 else 4'b1100;
- sb: low byte replicated to all four lanes, be 4'b0001 shifted left by addr[1:0].
REQ-023 For loads, dmem_we SHALL be 0 and dmem_be SHALL be 4'b1111.
REQ-024 Load formatting SHALL use lane = dmem_rdata >> (8*addr[1:0]) from the registered address:
- lb/lh: sign-extend lane[7:0] / lane[15:0];
- lbu/lhu: zero-extend them;
- lw: the full word.
REQ-025 On completion, the WB registers SHALL load:
- regwriteW = regwriteM && !misaligned;
- rdW = rdM;
- resultW = the mux per REQ-008 (load data for loads);
- misalignW = misaligned.
REQ-026 A store SHALL never set regwriteW, regardless of regwriteM.
REQ-027 Writes with rdW==0 SHALL pass unchanged; the register file discards them.
REQ-028 M-stage inputs are held by the upstream register while stallM=1; the block SHALL latch address, size and store data on entry to BUSY and SHALL NOT re-sample them.

Reset
REQ-029 Asserting rst at any time, including mid-BUSY, SHALL immediately force:
- state=IDLE;
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0;
- regwriteW=0, rdW=0, resultW=0, misalignW=0;
- stallM=0.
REQ-030 A memory ack arriving after reset release SHALL be ignored.
REQ-031 After rst deasserts, the first rising clk edge SHALL process the current M-stage inputs normally.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- ALU op: regwriteM=1, resultsrcM=0, aluresultM=0x1234, rdM=5 -> next edge regwriteW=1, rdW=5, resultW=0x1234, stallM=0 throughout, dmem_req never asserted.
- sb: addr=0x103, writeDataM=0x000000AB -> dmem_req=1, dmem_we=1, dmem_addr=0x100, dmem_be=4'b1000, dmem_wdata=0xABABABAB; with ack after 3 BUSY cycles, stallM high for 4 cycles; regwriteW=0.
- lb: addr=0x202, dmem_rdata=0x0080FF00, zero-wait ack -> resultW=0xFFFFFF80; repeat as lbu -> 0x00000080; lh at 0x202 -> 0x00000080 sign-extended from 0x0080.
- lw at addr=0x206 -> no dmem_req, stallM=0, misalignW=1, regwriteW=0 after 1 cycle.
- rst asserted in the 2nd BUSY cycle of a load -> dmem_req=0 and state=IDLE without waiting for a clock; a later ack pulse causes no WB update.
- Back-to-back: lw (ack immediately) followed by an ALU op -> WB shows the lw result, then the ALU result on consecutive cycles after the single-cycle stall.
